// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction
endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice; every carry is a flat sum-of-products of g/p/cin.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic       c1, c2, c3;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/cla_nibble_sequencer.sv
// Wide adder that reuses one 4-bit CLA slice, one nibble per cycle, LSB first,
// with valid/ready handshakes on operands and result.
module cla_nibble_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  localparam int NIB  = nib_count(WIDTH);
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic [IDXW-1:0]  idx;
  logic             carry_reg, a_msb, b_msb;
  logic [3:0]       s_nib;
  logic             s_co;

  cla4_slice u_slice (
    .a  (a_sh[NIBBLE_W-1:0]),
    .b  (b_sh[NIBBLE_W-1:0]),
    .cin(carry_reg),
    .s  (s_nib),
    .co (s_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_q     <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && !abort) begin
          state     <= RUN;
          a_sh      <= a;
          b_sh      <= b;
          carry_reg <= cin;
          idx       <= '0;
          a_msb     <= a[WIDTH-1];
          b_msb     <= b[WIDTH-1];
        end
        RUN: if (abort) begin
          state <= IDLE;
        end else begin
          // Write only the nibble currently in the slice; the rest of sum holds.
          for (int i = 0; i < NIB; i++)
            if (idx == IDXW'(i)) sum_q[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
          carry_reg <= s_co;
          a_sh      <= a_sh >> NIBBLE_W;
          b_sh      <= b_sh >> NIBBLE_W;
          idx       <= idx + 1'b1;
          if (idx == IDXW'(NIB - 1)) state <= DONE;
        end
        DONE: if (abort || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_reg;
  assign overflow  = (state == DONE) && (a_msb == b_msb) && (sum_q[WIDTH-1] != a_msb);
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer at WIDTH=16 (dut 0) and WIDTH=8 (dut 1) against an arithmetic model.
module tb_cla_nibble_sequencer;
  logic        clk = 1'b0;
  logic [1:0]  rst, abort, in_valid, cin, out_ready;
  logic [15:0] a_v [2];
  logic [15:0] b_v [2];

  logic        ir0, ov0, co0, of0, by0;
  logic        ir1, ov1, co1, of1, by1;
  logic [15:0] sum16;
  logic [7:0]  sum8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cla_nibble_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst[0]), .abort(abort[0]), .in_valid(in_valid[0]), .in_ready(ir0),
    .a(a_v[0]), .b(b_v[0]), .cin(cin[0]), .out_valid(ov0), .out_ready(out_ready[0]),
    .sum(sum16), .cout(co0), .overflow(of0), .busy(by0)
  );

  cla_nibble_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst[1]), .abort(abort[1]), .in_valid(in_valid[1]), .in_ready(ir1),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin[1]), .out_valid(ov1), .out_ready(out_ready[1]),
    .sum(sum8), .cout(co1), .overflow(of1), .busy(by1)
  );

  function automatic int wid(input int d);
    return (d != 0) ? 8 : 16;
  endfunction

  function automatic logic [15:0] sum_of(input int d);
    return (d != 0) ? {8'h00, sum8} : sum16;
  endfunction

  function automatic logic out_valid_of(input int d);
    return (d != 0) ? ov1 : ov0;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, got, exp, $time);
    end
  endtask

  // Transaction-level model: busy flag, cycles since accept, expected result from plain arithmetic.
  bit          m_init [2];
  bit          m_busy [2];
  int          m_k    [2];
  logic [15:0] e_sum  [2];
  bit          e_cout [2];
  bit          e_ov   [2];
  bit          h_valid[2];
  logic [15:0] h_sum  [2];
  bit          h_cout [2];

  always @(posedge clk) begin : model
    int w, msk, ua, ub, sa, sb, us, ss;
    for (int d = 0; d < 2; d++) begin
      w = wid(d);
      msk = (1 << w) - 1;
      if (rst[d]) begin
        m_init[d] = 1; m_busy[d] = 0; m_k[d] = 0;
        h_valid[d] = 1; h_sum[d] = '0; h_cout[d] = 0;
      end else if (!m_init[d]) begin
      end else if (!m_busy[d]) begin
        if (in_valid[d] && !abort[d]) begin
          ua = int'(a_v[d]) & msk;
          ub = int'(b_v[d]) & msk;
          sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
          sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
          us = ua + ub + int'(cin[d]);
          ss = sa + sb + int'(cin[d]);
          e_sum[d]  = 16'(us & msk);
          e_cout[d] = ((us >> w) & 1) != 0;
          e_ov[d]   = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
          m_busy[d] = 1; m_k[d] = 0; h_valid[d] = 0;
        end
      end else if (abort[d]) begin
        m_busy[d] = 0; h_valid[d] = 0;
      end else if (m_k[d] == w / 4) begin
        if (out_ready[d]) begin
          m_busy[d] = 0; h_valid[d] = 1; h_sum[d] = e_sum[d]; h_cout[d] = e_cout[d];
        end
      end else begin
        m_k[d]++;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit dn;
    for (int d = 0; d < 2; d++) begin
      if (m_init[d]) begin
        dn = m_busy[d] && (m_k[d] == wid(d) / 4);
        check("in_ready",  d, 32'((d != 0) ? ir1 : ir0), 32'(!m_busy[d]));
        check("busy",      d, 32'((d != 0) ? by1 : by0), 32'(m_busy[d]));
        check("out_valid", d, 32'(out_valid_of(d)), 32'(dn));
        if (dn) begin
          check("sum",      d, 32'(sum_of(d)), 32'(e_sum[d]));
          check("cout",     d, 32'((d != 0) ? co1 : co0), 32'(e_cout[d]));
          check("overflow", d, 32'((d != 0) ? of1 : of0), 32'(e_ov[d]));
        end else begin
          check("overflow_off", d, 32'((d != 0) ? of1 : of0), 32'd0);
          if (!m_busy[d] && h_valid[d]) begin
            check("sum_hold",  d, 32'(sum_of(d)), 32'(h_sum[d]));
            check("cout_hold", d, 32'((d != 0) ? co1 : co0), 32'(h_cout[d]));
          end
        end
      end
    end
  end

  // Caller must be between clock edges with the DUT idle; returns at posedge+1 (release) or at a DONE negedge.
  task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv, input bit ci,
                        input int stall, input bit release_it,
                        output logic [15:0] s, output bit co, output bit ovf, output int lat);
    bit got;
    in_valid[d] = 1; a_v[d] = av; b_v[d] = bv; cin[d] = ci; out_ready[d] = 0;
    @(posedge clk); #1;
    in_valid[d] = 0; a_v[d] = 16'($urandom); b_v[d] = 16'($urandom); cin[d] = 1'($urandom);
    lat = 0; got = 0; s = '0; co = 0; ovf = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid_of(d)) got = 1;
      else begin @(posedge clk); lat++; end
    end
    if (!got) begin
      check("result_timeout", d, 32'd0, 32'd1);
      return;
    end
    s   = sum_of(d);
    co  = (d != 0) ? co1 : co0;
    ovf = (d != 0) ? of1 : of0;
    for (int j = 0; j < stall; j++) begin @(posedge clk); #1; end
    if (release_it) begin
      out_ready[d] = 1;
      @(posedge clk); #1;
      out_ready[d] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    bit co, ovf;
    int lat;
    rst = 2'b11; abort = '0; in_valid = '0; cin = '0; out_ready = '0;
    a_v[0] = '0; b_v[0] = '0; a_v[1] = '0; b_v[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = '0;
    @(negedge clk);
    check("rst_in_ready", 0, 32'(ir0), 32'd1);
    check("rst_sum", 0, 32'(sum16), 32'd0);
    check("rst_out_valid", 1, 32'(ov1), 32'd0);
    @(posedge clk); #1;

    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 0, 1, s, co, ovf, lat);
    check("ffff_sum", 0, 32'(s), 32'h0000);
    check("ffff_cout", 0, 32'(co), 32'd1);
    check("ffff_ovf", 0, 32'(ovf), 32'd0);
    check("ffff_latency", 0, lat, 4);

    // Five-cycle stall in DONE, then an immediate back-to-back accept.
    run_op(0, 16'h1234, 16'h4321, 1'b1, 5, 1, s, co, ovf, lat);
    check("1234_sum", 0, 32'(s), 32'h5556);
    check("1234_cout", 0, 32'(co), 32'd0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 0, 1, s, co, ovf, lat);
    check("7fff_sum", 0, 32'(s), 32'h8000);
    check("7fff_ovf", 0, 32'(ovf), 32'd1);
    check("7fff_cout", 0, 32'(co), 32'd0);
    check("b2b_latency", 0, lat, 4);

    // Abort while idx=2.
    in_valid[0] = 1; a_v[0] = 16'h1111; b_v[0] = 16'h2222;
    @(posedge clk); #1 in_valid[0] = 0;
    repeat (2) begin @(posedge clk); #1; end
    abort[0] = 1;
    @(posedge clk); #1 abort[0] = 0;
    @(negedge clk);
    check("abort_in_ready", 0, 32'(ir0), 32'd1);
    check("abort_out_valid", 0, 32'(ov0), 32'd0);
    repeat (6) @(posedge clk);
    #1;

    // abort with in_valid in IDLE: the request is ignored.
    in_valid[0] = 1; abort[0] = 1;
    @(posedge clk); #1 in_valid[0] = 0; abort[0] = 0;
    @(negedge clk);
    check("idle_abort_busy", 0, 32'(by0), 32'd0);

    // Reset while in DONE.
    run_op(0, 16'hAAAA, 16'h5555, 1'b1, 0, 0, s, co, ovf, lat);
    rst[0] = 1;
    @(posedge clk); #1 rst[0] = 0;
    @(negedge clk);
    check("rstdone_out_valid", 0, 32'(ov0), 32'd0);
    check("rstdone_sum", 0, 32'(sum16), 32'd0);
    check("rstdone_cout", 0, 32'(co0), 32'd0);
    check("rstdone_in_ready", 0, 32'(ir0), 32'd1);
    run_op(0, 16'h0F0F, 16'hF0F1, 1'b0, 0, 1, s, co, ovf, lat);
    check("0f0f_sum", 0, 32'(s), 32'h0000);
    check("0f0f_cout", 0, 32'(co), 32'd1);

    // Abort in DONE together with out_ready.
    run_op(0, 16'h8000, 16'h8000, 1'b0, 1, 0, s, co, ovf, lat);
    check("8000_ovf", 0, 32'(ovf), 32'd1);
    abort[0] = 1; out_ready[0] = 1;
    @(posedge clk); #1 abort[0] = 0; out_ready[0] = 0;

    run_op(1, 16'h0080, 16'h0080, 1'b0, 0, 1, s, co, ovf, lat);
    check("w8_sum", 1, 32'(s), 32'h00);
    check("w8_cout", 1, 32'(co), 32'd1);
    check("w8_ovf", 1, 32'(ovf), 32'd1);
    check("w8_latency", 1, lat, 2);

    for (int i = 0; i < 1000; i++)
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2), 1, s, co, ovf, lat);
    for (int i = 0; i < 200; i++)
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2), 1, s, co, ovf, lat);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
